execute_writeback_unit: RTL

- Execute stage directly downstream of the 32x32 register file.
- Latches the two read operands and an op code, computes an ALU result or runs an iterative multiply, then drives the register file write port (W_Addr, W_Data, Write_Reg) for exactly one cycle per instruction.
- Uses a valid/ready handshake toward the decode/issue logic.

---
 rtl/execute_writeback_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/execute_writeback_unit.sv
// Execute/writeback stage behind the 32x32 register file: ALU ops in one EXEC cycle,
// iterative shift-add MUL, one-cycle register write strobe. Optional macro: ZERO_REG_GUARD_EN.
module execute_writeback_unit #(
  parameter int ADDR_WIDTH         = 5,
  parameter int DATA_WIDTH         = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [3:0]            ALU_OP,
  input  logic [DATA_WIDTH-1:0] R_Data_A,
  input  logic [DATA_WIDTH-1:0] R_Data_B,
  input  logic [ADDR_WIDTH-1:0] Dest_Addr,
  input  logic                  Write_En_In,
  output logic [ADDR_WIDTH-1:0] W_Addr,
  output logic [DATA_WIDTH-1:0] W_Data,
  output logic                  Write_Reg,
  output logic                  Overflow,
  output logic                  Illegal,
  output logic                  Busy
);

  localparam int MUL_N = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CNT_W = (MUL_N > 1) ? $clog2(MUL_N) : 1;
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int MSB   = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_e;

  typedef enum logic [3:0] {
    OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
    OP_SLT = 4'd4, OP_NOR = 4'd5, OP_XOR = 4'd6, OP_SLL = 4'd7,
    OP_SRL = 4'd8, OP_MUL = 4'd9, OP_SRA = 4'd10
  } op_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  write_reg_q, write_reg_d;
  logic                  overflow_q, overflow_d;
  logic                  illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0] sum, diff, alu_res, mul_step;
  logic [SH_W-1:0]       sh_amt;
  logic                  alu_ovf, alu_legal, wr_allow;

  assign sum    = a_q + b_q;
  assign diff   = a_q - b_q;
  assign sh_amt = a_q[SH_W-1:0];

`ifdef ZERO_REG_GUARD_EN
  assign wr_allow = we_q && (dest_q != '0);
`else
  assign wr_allow = we_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_legal = 1'b1;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = b_q << sh_amt;
      OP_SRL: alu_res = b_q >> sh_amt;
      OP_SRA: alu_res = $signed(b_q) >>> sh_amt;
      OP_MUL: alu_res = '0;
      default: alu_legal = 1'b0;
    endcase
  end

  // One shift-add step: add A shifted by each of the low MUL_BITS_PER_CYCLE bits of B.
  // A shifts left and B shifts right after each step, so bit 0 of B is always the next digit.
  always_comb begin
    mul_step = acc_q;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (b_q[j]) mul_step = mul_step + (a_q << j);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dest_d      = dest_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    write_reg_d = 1'b0;
    overflow_d  = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (In_Valid) begin
          op_d    = ALU_OP;
          a_d     = R_Data_A;
          b_d     = R_Data_B;
          dest_d  = Dest_Addr;
          we_d    = Write_En_In;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end else if (alu_legal) begin
          w_data_d    = alu_res;
          w_addr_d    = dest_q;
          write_reg_d = wr_allow;
          overflow_d  = alu_ovf;
          state_d     = S_IDLE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        a_d   = a_q << MUL_BITS_PER_CYCLE;
        b_d   = b_q >> MUL_BITS_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_N - 1)) begin
          cnt_d       = '0;
          w_data_d    = mul_step;
          w_addr_d    = dest_q;
          write_reg_d = wr_allow;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dest_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      write_reg_q <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dest_q      <= dest_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      write_reg_q <= write_reg_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign In_Ready  = (state_q == S_IDLE);
  assign Busy      = !In_Ready;
  assign W_Addr    = w_addr_q;
  assign W_Data    = w_data_q;
  assign Write_Reg = write_reg_q;
  assign Overflow  = overflow_q;
  assign Illegal   = illegal_q;

endmodule
